// File: rtl/ram_dual_pkg.sv
// Shared defaults and types for the dual-port scratch RAM.
// Consumed by ram_dual_array and ram_dual_port.
package ram_dual_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

endpackage : ram_dual_pkg

// File: rtl/ram_dual_array.sv
// Flop-based storage array: async-cleared words, one-hot write decode,
// and a combinational read mux that returns the contents before the edge.
module ram_dual_array
  import ram_dual_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  logic [MEM_DEPTH-1:0]  w_wr_sel;
  logic [DATA_WIDTH-1:0] w_words [MEM_DEPTH];

  // Each word is its own register so every entry clears on reset.
  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] r_word;

    assign w_wr_sel[gi] = i_we && (i_write_addr == ADDR_WIDTH'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (w_wr_sel[gi]) begin
        r_word <= i_data;
      end
    end

    assign w_words[gi] = r_word;
  end

  assign o_rdata = w_words[i_read_addr];

endmodule : ram_dual_array

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM with registered read (1-cycle latency), read-first on
// same-address collisions; RAM_DUAL_WRITE_THROUGH_EN makes collisions write-through.
module ram_dual_port
  import ram_dual_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_q_next;
  logic [DATA_WIDTH-1:0] r_q;

  ram_dual_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_we         (we),
    .i_write_addr (write_addr),
    .i_data       (data),
    .i_read_addr  (read_addr),
    .o_rdata      (w_rdata)
  );

`ifdef RAM_DUAL_WRITE_THROUGH_EN
  logic w_bypass;

  // Forward incoming data when this edge writes the word being read.
  assign w_bypass = we && (write_addr == read_addr);
  assign w_q_next = w_bypass ? data : w_rdata;
`else
  assign w_q_next = w_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule : ram_dual_port

// File: tb/tb_ram_dual_port.sv
// Directed self-checking bench for ram_dual_port; honours RAM_DUAL_WRITE_THROUGH_EN.
module tb_ram_dual_port;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [5:0] write_addr;
  logic       we;
  logic [5:0] read_addr;
  logic [7:0] q;

  int checks   = 0;
  int failures = 0;

`ifdef RAM_DUAL_WRITE_THROUGH_EN
  localparam logic [7:0] COLLIDE_EXP = 8'hC3;
`else
  localparam logic [7:0] COLLIDE_EXP = 8'h3C;
`endif

  ram_dual_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .write_addr (write_addr),
    .we         (we),
    .read_addr  (read_addr),
    .q          (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    end else begin
      $display("ok   %s q=0x%02h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [7:0] val);
    we         = 1'b1;
    write_addr = addr;
    data       = val;
    tick();
    we         = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] addr, input logic [7:0] exp);
    read_addr = addr;
    tick();
    check(tag, q, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    we         = 1'b1;
    data       = 8'hFF;
    write_addr = 6'd0;
    read_addr  = 6'd0;

    // Writes attempted while reset is held must be ignored.
    repeat (3) tick();
    check("reset_q", q, 8'h00);
    we    = 1'b0;
    rst_n = 1'b1;

    rd_check("rst_rd0",  6'd0,  8'h00);
    rd_check("rst_rd17", 6'd17, 8'h00);
    rd_check("rst_rd63", 6'd63, 8'h00);

    // Basic write then read with 1-cycle latency.
    wr(6'd3, 8'hA5);
    read_addr = 6'd3;
    #2;
    check("hold_before_edge", q, 8'h00);
    tick();
    check("basic_rd3", q, 8'hA5);

    // we=0 leaves the array untouched.
    we = 1'b0; write_addr = 6'd10; data = 8'hFF;
    tick();
    rd_check("we_gate_rd10", 6'd10, 8'h00);

    // Boundary addresses.
    wr(6'd0,  8'h11);
    wr(6'd63, 8'h22);
    rd_check("bound_rd0",  6'd0,  8'h11);
    rd_check("bound_rd63", 6'd63, 8'h22);
    rd_check("bound_rd62", 6'd62, 8'h00);

    // Same-address collision.
    wr(6'd5, 8'h3C);
    read_addr = 6'd5;
    wr(6'd5, 8'hC3);
    check("collide_rd5", q, COLLIDE_EXP);
    tick();
    check("collide_next_rd5", q, 8'hC3);

    // Different-address read during write is unaffected.
    read_addr = 6'd3;
    wr(6'd4, 8'h77);
    check("indep_rd3", q, 8'hA5);

    // Back-to-back streaming fill then drain.
    for (int k = 0; k < 64; k++) begin
      wr(6'(k), 8'(k + 1));
    end
    for (int k = 0; k < 64; k++) begin
      rd_check($sformatf("stream_rd%0d", k), 6'(k), 8'(k + 1));
    end

    // Reset asserted mid-stream clears q at once and the array for later reads.
    for (int k = 0; k < 17; k++) begin
      read_addr = 6'(k);
      tick();
    end
    check("pre_rst_rd16", q, 8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midstream_rst_q", q, 8'h00);
    we = 1'b1; write_addr = 6'd20; data = 8'h99;
    tick();
    tick();
    we    = 1'b0;
    rst_n = 1'b1;
    for (int k = 17; k < 32; k++) begin
      rd_check($sformatf("post_rst_rd%0d", k), 6'(k), 8'h00);
    end
    rd_check("post_rst_rd0",  6'd0,  8'h00);
    rd_check("post_rst_rd5",  6'd5,  8'h00);
    rd_check("post_rst_rd63", 6'd63, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_dual_port
